// File: rtl/seg7_scan_decoder_if.sv
// Scanned 7-segment display bus into the decoder and decoded frame results out of it.
interface seg7_scan_decoder_if;
  logic        i_w_AN0, i_w_AN1, i_w_AN2, i_w_AN3;
  logic        i_w_CA, i_w_CB, i_w_CC, i_w_CD, i_w_CE, i_w_CF, i_w_CG;
  logic        i_w_DP;
  logic [15:0] o_r_value;
  logic [3:0]  o_r_dp;
  logic        o_r_valid;
  logic        o_r_err;
  logic        o_r_timeout;

  modport slave (
    input  i_w_AN0, i_w_AN1, i_w_AN2, i_w_AN3,
    input  i_w_CA, i_w_CB, i_w_CC, i_w_CD, i_w_CE, i_w_CF, i_w_CG,
    input  i_w_DP,
    output o_r_value, o_r_dp, o_r_valid, o_r_err, o_r_timeout
  );

  modport master (
    output i_w_AN0, i_w_AN1, i_w_AN2, i_w_AN3,
    output i_w_CA, i_w_CB, i_w_CC, i_w_CD, i_w_CE, i_w_CF, i_w_CG,
    output i_w_DP,
    input  o_r_value, o_r_dp, o_r_valid, o_r_err, o_r_timeout
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed, active-low 7-segment display scan.
// Define SEG7_SCAN_DECODER_DP_EN to capture per-digit decimal points.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  seg7_scan_decoder_if.slave bus
);

  localparam int unsigned VEC_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;

  logic [VEC_W-1:0] raw_c, sync1, sync2, prev;
  logic [CNT_W-1:0] stab_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [15:0]      digits;
  logic [3:0]       mask;
  logic             err;
  logic             dp_in_c;
  logic [3:0]       an_c;
  logic [1:0]       idx_c;
  logic             active_c, same_c, capture_c, complete_c, timeout_c, clear_c;
  logic [4:0]       dec_c;

`ifdef SEG7_SCAN_DECODER_DP_EN
  logic [3:0] dps;
  assign dp_in_c = bus.i_w_DP;
`else
  logic unused_dp;
  assign unused_dp = bus.i_w_DP;
  assign dp_in_c   = 1'b1;
`endif

  assign raw_c = {bus.i_w_AN3, bus.i_w_AN2, bus.i_w_AN1, bus.i_w_AN0,
                  bus.i_w_CG, bus.i_w_CF, bus.i_w_CE, bus.i_w_CD,
                  bus.i_w_CC, bus.i_w_CB, bus.i_w_CA, dp_in_c};

  // Returns {decodable, nibble} for an active-low {g..a} pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    active_c = 1'b0;
    idx_c    = 2'd0;
    an_c     = sync2[11:8];
    case (an_c)
      4'b1110: begin active_c = 1'b1; idx_c = 2'd0; end
      4'b1101: begin active_c = 1'b1; idx_c = 2'd1; end
      4'b1011: begin active_c = 1'b1; idx_c = 2'd2; end
      4'b0111: begin active_c = 1'b1; idx_c = 2'd3; end
      default: begin active_c = 1'b0; idx_c = 2'd0; end
    endcase
  end

  assign same_c     = (sync2 == prev);
  // Fires once per dwell: the cycle the run of identical samples reaches STABLE_CYCLES.
  assign capture_c  = active_c && same_c && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign dec_c      = decode(sync2[7:1]);
  assign complete_c = (mask == 4'hF);
  assign timeout_c  = !complete_c && (mask != 4'h0) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign clear_c    = complete_c || timeout_c;

  // Synchronizers and stability tracking.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      sync1    <= '1;
      sync2    <= '1;
      prev     <= '1;
      stab_cnt <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      prev  <= sync2;
      if (!active_c || !same_c)
        stab_cnt <= '0;
      else if (stab_cnt != '1)
        stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end

  // Frame assembly, timeout and registered results; a capture coinciding with a
  // completion or timeout starts the next frame.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      digits      <= '0;
      mask        <= '0;
      err         <= 1'b0;
      to_cnt      <= '0;
      bus.o_r_value   <= '0;
      bus.o_r_dp      <= '0;
      bus.o_r_valid   <= 1'b0;
      bus.o_r_err     <= 1'b0;
      bus.o_r_timeout <= 1'b0;
`ifdef SEG7_SCAN_DECODER_DP_EN
      dps         <= '0;
`endif
    end else begin
      mask <= (clear_c ? 4'h0 : mask) | (capture_c ? (4'b0001 << idx_c) : 4'h0);
      err  <= (clear_c ? 1'b0 : err) | (capture_c && !dec_c[4]);
      if (clear_c || mask == 4'h0)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);
      if (capture_c) begin
        digits[{idx_c, 2'b00} +: 4] <= dec_c[3:0];
`ifdef SEG7_SCAN_DECODER_DP_EN
        dps[idx_c] <= ~sync2[0];
`endif
      end
      bus.o_r_valid   <= complete_c;
      bus.o_r_timeout <= timeout_c;
      if (complete_c) begin
        bus.o_r_value <= digits;
        bus.o_r_err   <= err;
`ifdef SEG7_SCAN_DECODER_DP_EN
        bus.o_r_dp    <= dps;
`else
        bus.o_r_dp    <= 4'h0;
`endif
      end
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured, range 2..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles allowed between frame starts, range 16..65535.
REQ-004 Port i_w_clk  input  1  rising-edge clock.
REQ-005 Port i_w_reset  input  1  asynchronous active-low reset.
REQ-006 Ports i_w_AN0..i_w_AN3  input  1 each  anode selects, active-low; AN0 is the least significant digit.
REQ-007 Ports i_w_CA..i_w_CG  input  1 each  segments a..g, active-low.
REQ-008 Port i_w_DP  input  1  decimal point, active-low.
REQ-009 Port o_r_value  output  16  decoded frame; digit n is in bits [4n+3:4n].
REQ-010 Port o_r_dp  output  4  decimal point per digit, 1 = lit.
REQ-011 Port o_r_valid  output  1  one-cycle pulse when a frame completes.
REQ-012 Port o_r_err  output  1  qualified by o_r_valid: at least one digit in the frame had an undecodable pattern.
REQ-013 Port o_r_timeout  output  1  one-cycle pulse when a partial frame is abandoned.

Function
REQ-014 All inputs SHALL pass through a 2-flop synchronizer; functional latency is counted from the synchronized samples.
REQ-015 A sample SHALL be active only if exactly one AN is low; zero or multiple low ANs SHALL reset the stability counter and capture nothing.
REQ-016 Stability counter: increments while the synchronized {AN, seg, DP} vector equals the previous sample, resets to 0 on any change, and saturates.
REQ-017 A digit SHALL be captured exactly once per dwell, on the cycle when the identical count reaches STABLE_CYCLES; it is not recaptured until the vector changes.
REQ-018 Decoding of {CG..CA}, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 Any other segment pattern SHALL store nibble 0x0 and set the frame error flag.
REQ-020 Each capture SHALL set its digit's bit in a 4-bit captured mask; recapturing an already-captured digit before the frame completes SHALL overwrite that digit's nibble and DP.
REQ-021 When the mask becomes 4'b1111, the block SHALL, on the next cycle:
  - update o_r_value, o_r_dp and o_r_err;
  - pulse o_r_valid;
  - clear the mask and the error flag.
REQ-022 o_r_value, o_r_dp and o_r_err SHALL hold their values between valid pulses.
REQ-023 Timeout counter: cleared on each frame completion and on each first capture into an empty mask; increments otherwise while the mask is non-zero.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse o_r_timeout, clear the mask and error flag, and leave the outputs unchanged.
REQ-025 If timeout and frame completion occur in the same cycle, frame completion SHALL win and no timeout pulse is issued.
REQ-026 o_r_valid and o_r_timeout SHALL never be asserted in the same cycle.

Reset
REQ-027 Reset asserted at any time SHALL immediately clear all of the following:
  - synchronizers (to all-ones, i.e. inactive);
  - counters, captured mask and error flag;
  - o_r_value=16'h0000, o_r_dp=4'h0, o_r_valid=0, o_r_err=0, o_r_timeout=0.
REQ-028 A frame in progress when reset asserts SHALL be discarded; after deassertion, capture restarts from an empty mask.

Configuration
REQ-029 Macro SEG7_SCAN_DECODER_DP_EN defined: DP is captured per digit into o_r_dp, and DP is part of the stability vector.
REQ-030 Macro SEG7_SCAN_DECODER_DP_EN undefined: o_r_dp SHALL be constant 4'h0, and i_w_DP SHALL be ignored, including for stability.

Verification
REQ-031 Scan AN0..AN3 for 10 cycles each with digits 1,2,3,4 and DP off -> a single o_r_valid pulse, o_r_value=16'h4321, o_r_err=0.
REQ-032 Same scan with AN2 carrying 7'b1111111 -> o_r_valid pulse, o_r_value=16'h4021, o_r_err=1.
REQ-033 AN0 toggling its pattern every 2 cycles with STABLE_CYCLES=4 -> no capture; after TIMEOUT_CYCLES no timeout occurs, because the mask is empty.
REQ-034 Capture digits 0 and 1 only, then all AN high for TIMEOUT_CYCLES -> one o_r_timeout pulse, no o_r_valid, outputs unchanged.
REQ-035 Reset pulsed after 3 digits are captured, followed by a full scan of F,E,d,C -> o_r_value=16'hCDEF; no valid pulse from the pre-reset data.
REQ-036 With SEG7_SCAN_DECODER_DP_EN defined, scan 8,8,8,8 with DP low on AN1 only -> o_r_value=16'h8888, o_r_dp=4'b0010; with the macro undefined -> o_r_dp=4'b0000.
